// File: rtl/spi_ctrl_pkg.sv
// Shared constants for the SPI controller: register offsets, bit positions
// and the shift-engine state encoding.
package spi_ctrl_pkg;

    localparam logic [4:0] OFS_CTRL   = 5'h00;
    localparam logic [4:0] OFS_DIV    = 5'h04;
    localparam logic [4:0] OFS_TXDATA = 5'h08;
    localparam logic [4:0] OFS_RXDATA = 5'h0C;
    localparam logic [4:0] OFS_STATUS = 5'h10;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_IE   = 1;
    localparam int STAT_BUSY = 0;
    localparam int STAT_RXV  = 1;
    localparam int STAT_OVR  = 2;

    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} eng_state_t;

    // Word-aligned address inside the five-register window.
    function automatic logic decode_ok(input logic [31:0] addr);
        return (addr[31:5] == '0) && (addr[1:0] == 2'b00) && (addr[4:2] <= 3'd4);
    endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// Mode-0 SPI master shift engine: one DATA_W-bit frame per start pulse,
// half-period of (div+1) clk cycles, MSB first.
module spi_shift_engine
    import spi_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIV_W-1:0]  div,
    input  logic [DATA_W-1:0] txword,
    input  logic              miso,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rxword,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n
);

    localparam logic [5:0] BIT_LAST = 6'(DATA_W - 1);

    eng_state_t        state;
    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  div_q;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic [DATA_W-1:0] tx_next;
    logic [DATA_W-1:0] rx_next;
    logic [5:0]        bit_cnt;

    always_comb begin
        tx_next    = tx_sh << 1;
        rx_next    = rx_sh << 1;
        rx_next[0] = miso;
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, exactly like the flops it describes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            div_q   <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            bit_cnt <= '0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            cs_n    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= LEAD;
                        div_q   <= div;
                        cnt     <= div;
                        tx_sh   <= txword;
                        rx_sh   <= '0;
                        bit_cnt <= '0;
                        cs_n    <= 1'b0;
                        mosi    <= txword[DATA_W-1];
                    end
                end
                LEAD: begin
                    if (cnt == '0) begin
                        state <= SHIFT;
                        cnt   <= div_q;
                    end else begin
                        cnt <= cnt - DIV_W'(1);
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - DIV_W'(1);
                    end else begin
                        cnt <= div_q;
                        // Low phase ends: rise and sample; high phase ends: fall and shift.
                        if (!sclk) begin
                            sclk  <= 1'b1;
                            rx_sh <= rx_next;
                        end else begin
                            sclk  <= 1'b0;
                            tx_sh <= tx_next;
                            mosi  <= tx_next[DATA_W-1];
                            if (bit_cnt == BIT_LAST) begin
                                state <= TRAIL;
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                            end
                        end
                    end
                end
                TRAIL: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        cs_n  <= 1'b1;
                        mosi  <= 1'b0;
                    end else begin
                        cnt <= cnt - DIV_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy   = (state != IDLE);
    assign done   = (state == TRAIL) && (cnt == '0);
    assign rxword = rx_sh;

endmodule

// File: rtl/spi_ctrl.sv
// SPI controller top: register bank and request/strobe handshake in front
// of the shift engine.
module spi_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] waddr,
    input  logic [31:0] raddr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        wack,
    output logic        rack,
    output logic        waddrerr,
    output logic        raddrerr,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic        cs_n,
    output logic        irq
);

    logic [1:0]        ctrl;
    logic [DIV_W-1:0]  div;
    logic [DATA_W-1:0] tx_word;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              overrun;
    logic              start_q;

    logic              eng_busy;
    logic              eng_done;
    logic [DATA_W-1:0] eng_rx;

    logic              busy;
    logic              strobe;
    logic              w_ok, r_ok;
    logic [4:0]        w_ofs, r_ofs;
    logic              wr_stall, wr_go, rd_go;
    logic [31:0]       rd_val;
    logic              unused_wdata;

    // Write data bits beyond each register field are ignored.
    assign unused_wdata = ^wdata;

    assign busy   = start_q | eng_busy;
    assign strobe = wack | rack | waddrerr | raddrerr;
    assign w_ok   = decode_ok(waddr);
    assign r_ok   = decode_ok(raddr);
    assign w_ofs  = waddr[4:0];
    assign r_ofs  = raddr[4:0];

    // A TXDATA write during a transfer is held off (no strobe) rather than
    // rejected; the requester keeps wr_en high until the engine is free.
    assign wr_stall = w_ok && (w_ofs == OFS_TXDATA) && ctrl[CTRL_EN] && busy;
    assign wr_go    = wr_en && !strobe && !wr_stall;
    assign rd_go    = rd_en && !strobe && !wr_go;

    always_comb begin
        rd_val = '0;
        case (r_ofs)
            OFS_CTRL:   rd_val = 32'(ctrl);
            OFS_DIV:    rd_val = 32'(div);
            OFS_RXDATA: rd_val = 32'(rx_data);
            OFS_STATUS: rd_val = 32'({overrun, rx_valid, busy});
            default:    rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl     <= '0;
            div      <= '0;
            tx_word  <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
            start_q  <= 1'b0;
            rdata    <= '0;
            wack     <= 1'b0;
            rack     <= 1'b0;
            waddrerr <= 1'b0;
            raddrerr <= 1'b0;
        end else begin
            wack     <= 1'b0;
            rack     <= 1'b0;
            waddrerr <= 1'b0;
            raddrerr <= 1'b0;
            start_q  <= 1'b0;

            if (wr_go) begin
                if (!w_ok) begin
                    waddrerr <= 1'b1;
                end else begin
                    case (w_ofs)
                        OFS_CTRL: begin
                            ctrl <= wdata[1:0];
                            wack <= 1'b1;
                        end
                        OFS_DIV: begin
                            div  <= wdata[DIV_W-1:0];
                            wack <= 1'b1;
                        end
                        OFS_TXDATA: begin
                            if (ctrl[CTRL_EN]) begin
                                tx_word <= wdata[DATA_W-1:0];
                                start_q <= 1'b1;
                                wack    <= 1'b1;
                            end else begin
                                waddrerr <= 1'b1;
                            end
                        end
                        OFS_STATUS: begin
                            if (wdata[STAT_OVR]) overrun <= 1'b0;
                            wack <= 1'b1;
                        end
                        default: waddrerr <= 1'b1;
                    endcase
                end
            end

            if (rd_go) begin
                if (!r_ok) begin
                    raddrerr <= 1'b1;
                end else begin
                    rdata <= rd_val;
                    rack  <= 1'b1;
                    if (r_ofs == OFS_RXDATA) rx_valid <= 1'b0;
                end
            end

            // Placed last so a completing frame wins over a same-cycle clear.
            if (eng_done) begin
                rx_data  <= eng_rx;
                rx_valid <= 1'b1;
                if (rx_valid) overrun <= 1'b1;
            end
        end
    end

    assign irq = ctrl[CTRL_IE] & rx_valid;

    spi_shift_engine #(
        .DATA_W (DATA_W),
        .DIV_W  (DIV_W)
    ) u_engine (
        .clk    (clk),
        .rst    (rst),
        .start  (start_q),
        .div    (div),
        .txword (tx_word),
        .miso   (miso),
        .busy   (eng_busy),
        .done   (eng_done),
        .rxword (eng_rx),
        .sclk   (sclk),
        .mosi   (mosi),
        .cs_n   (cs_n)
    );

endmodule

// File: tb/tb_spi_ctrl.sv
// Self-checking bench for spi_ctrl: directed register/handshake cases plus
// randomized frames checked against a transaction-level model.
module tb_spi_ctrl;

    localparam int W      = 8;
    localparam int DW     = 8;
    localparam int BUDGET = 400;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] waddr, raddr, wdata;
    logic [31:0] rdata;
    logic        wack, rack, waddrerr, raddrerr;
    logic        sclk, mosi, miso, cs_n, irq;
    logic        loopback;
    logic        slv_miso = 1'b0;

    assign miso = loopback ? mosi : slv_miso;

    always #5 clk = ~clk;

    spi_ctrl #(.DATA_W(W), .DIV_W(DW)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .waddr(waddr), .raddr(raddr), .wdata(wdata), .rdata(rdata),
        .wack(wack), .rack(rack), .waddrerr(waddrerr), .raddrerr(raddrerr),
        .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n), .irq(irq)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pad-side monitor and SPI slave: records each frame, drives miso from slave_word.
    typedef struct {
        logic [31:0] mosi_word;
        int          nbits;
        int          low;
        int          rise_cyc;
    } frame_t;

    frame_t         frames[$];
    logic [31:0]    mon_bits = '0;
    int             mon_nbits = 0;
    int             mon_low = 0;
    logic           prev_cs = 1'b1;
    logic           prev_sclk = 1'b0;
    logic [W-1:0]   slave_word = '0;
    logic [W-1:0]   slv_sh = '0;

    always @(negedge clk) begin
        frame_t f;
        if (prev_cs && !cs_n) begin
            mon_bits  = '0;
            mon_nbits = 0;
            mon_low   = 0;
            slv_sh    = slave_word;
            slv_miso  = slv_sh[W-1];
        end
        if (!cs_n) mon_low++;
        if (sclk && !prev_sclk) begin
            mon_bits = {mon_bits[30:0], mosi};
            mon_nbits++;
        end
        if (!sclk && prev_sclk) begin
            slv_sh   = slv_sh << 1;
            slv_miso = slv_sh[W-1];
        end
        if (!prev_cs && cs_n) begin
            f.mosi_word = mon_bits;
            f.nbits     = mon_nbits;
            f.low       = mon_low;
            f.rise_cyc  = cyc;
            frames.push_back(f);
        end
        prev_cs   = cs_n;
        prev_sclk = sclk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // resp: 0 = ack, 1 = error, 2 = no response within budget
    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, output int resp, output int at);
        @(negedge clk);
        waddr = a; wdata = d; wr_en = 1'b1;
        resp = 2; at = 0;
        for (int i = 0; i < BUDGET && resp == 2; i++) begin
            @(negedge clk);
            if (wack || waddrerr) begin
                resp = wack ? 0 : 1;
                at   = cyc;
            end
        end
        // Requester drops wr_en one cycle after the strobe; no second strobe may follow.
        @(negedge clk);
        if (resp != 2) check("wr_oneshot", 32'({wack, waddrerr}), 32'd0);
        wr_en = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output int resp, output logic [31:0] d);
        @(negedge clk);
        raddr = a; rd_en = 1'b1;
        resp = 2; d = '0;
        for (int i = 0; i < BUDGET && resp == 2; i++) begin
            @(negedge clk);
            if (rack || raddrerr) begin
                resp = rack ? 0 : 1;
                d    = rdata;
            end
        end
        @(negedge clk);
        if (resp != 2) check("rd_oneshot", 32'({rack, raddrerr}), 32'd0);
        rd_en = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d, input int exp_resp);
        int r, t;
        bus_wr(a, d, r, t);
        check(tag, 32'(r), 32'(exp_resp));
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        int r;
        logic [31:0] d;
        bus_rd(a, r, d);
        check({tag, "_resp"}, 32'(r), 32'd0);
        if (r == 0) check(tag, d, exp);
    endtask

    task automatic rd_err(input string tag, input logic [31:0] a);
        int r;
        logic [31:0] d;
        bus_rd(a, r, d);
        check(tag, 32'(r), 32'd1);
    endtask

    task automatic wait_frames(input int n);
        for (int i = 0; i < 4 * BUDGET && frames.size() < n; i++) @(negedge clk);
        check("frame_wait", 32'(frames.size() >= n), 32'd1);
    endtask

    task automatic check_frame(input int idx, input logic [W-1:0] tx, input int d);
        if (idx < frames.size()) begin
            check("frame_len", 32'(frames[idx].low), 32'((2 * W + 2) * (d + 1)));
            check("frame_bits", 32'(frames[idx].nbits), 32'(W));
            check("frame_mosi", 32'(frames[idx].mosi_word[W-1:0]), 32'(tx));
        end
    endtask

    // Reference model of the register-visible state
    logic [1:0]   m_ctrl;
    logic [DW-1:0] m_div;
    logic [W-1:0] m_rx;
    logic         m_rxv, m_ovr;

    initial begin
        int r, t1, t2, nf, fdiv;
        logic [31:0] tx, wd;

        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        waddr = '0; raddr = '0; wdata = '0; loopback = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_csn", 32'(cs_n), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_strobes", 32'({wack, rack, waddrerr, raddrerr}), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        rd("rst_status", 32'h10, 32'h0);

        // Loopback frame, DIV=1 -> H=2
        wr("wr_ctrl", 32'h00, 32'h1, 0);
        wr("wr_div", 32'h04, 32'h1, 0);
        wr("wr_tx_a5", 32'h08, 32'hA5, 0);
        rd("st_busy", 32'h10, 32'h1);
        wait_frames(1);
        check_frame(0, 8'hA5, 1);
        rd("st_rxv", 32'h10, 32'h2);
        check("irq_ie0", 32'(irq), 32'd0);
        rd("rx_a5", 32'h0C, 32'hA5);
        rd("st_clear", 32'h10, 32'h0);

        // Back-to-back: second TXDATA write is held until the first frame ends
        bus_wr(32'h08, 32'h3C, r, t1);
        check("b2b_ack1", 32'(r), 32'd0);
        bus_wr(32'h08, 32'hC3, r, t2);
        check("b2b_ack2", 32'(r), 32'd0);
        wait_frames(3);
        check_frame(1, 8'h3C, 1);
        check_frame(2, 8'hC3, 1);
        if (frames.size() >= 2) check("b2b_order", 32'(t2 > frames[1].rise_cyc), 32'd1);
        rd("st_ovr", 32'h10, 32'h6);
        wr("w1c_ovr", 32'h10, 32'h4, 0);
        rd("st_after_w1c", 32'h10, 32'h2);
        rd("rx_c3", 32'h0C, 32'hC3);

        // Error responses
        wr("err_wr_rx", 32'h0C, 32'h55, 1);
        rd_err("err_rd_14", 32'h14);
        rd_err("err_rd_02", 32'h02);
        wr("err_wr_20", 32'h20, 32'h0, 1);
        wr("err_wr_hi", 32'h1000_0000, 32'h0, 1);
        rd("rd_tx_zero", 32'h08, 32'h0);
        rd("rd_div", 32'h04, 32'h1);
        wr("ctrl_off", 32'h00, 32'h0, 0);
        wr("err_tx_dis", 32'h08, 32'h11, 1);
        check("no_new_frame", 32'(frames.size()), 32'd3);

        // Randomized frames against the model, real slave on miso
        loopback = 1'b0;
        nf = 3;
        m_div = 8'd1; m_rx = 8'hC3; m_rxv = 1'b0; m_ovr = 1'b0;
        m_ctrl = {1'($urandom_range(0, 1)), 1'b1};
        wr("rnd_ctrl", 32'h00, 32'(m_ctrl), 0);
        for (int it = 0; it < 10; it++) begin
            if (it == 0 || $urandom_range(0, 1) == 1) begin
                m_div = DW'($urandom_range(0, 3));
                wr("rnd_div", 32'h04, 32'(m_div), 0);
            end
            tx = $urandom;
            slave_word = W'($urandom);
            fdiv = int'(m_div);
            wr("rnd_tx", 32'h08, tx, 0);
            case ($urandom_range(0, 3))
                1: begin
                    m_div = DW'($urandom_range(0, 3));
                    wr("rnd_div_mid", 32'h04, 32'(m_div), 0);
                end
                2: begin
                    m_ctrl[0] = 1'b0;
                    wr("rnd_en_off", 32'h00, 32'(m_ctrl), 0);
                end
                default: ;
            endcase
            wait_frames(nf + 1);
            check_frame(nf, tx[W-1:0], fdiv);
            nf++;
            m_ovr = m_ovr | m_rxv;
            m_rxv = 1'b1;
            m_rx  = slave_word;
            check("rnd_irq", 32'(irq), 32'(m_ctrl[1] & m_rxv));
            rd("rnd_status", 32'h10, 32'({m_ovr, m_rxv, 1'b0}));
            if (!m_ctrl[0]) begin
                m_ctrl[0] = 1'b1;
                wr("rnd_en_on", 32'h00, 32'(m_ctrl), 0);
            end
            if ($urandom_range(0, 1) == 1) begin
                rd("rnd_rx", 32'h0C, 32'(m_rx));
                m_rxv = 1'b0;
            end
            if ($urandom_range(0, 2) == 0) begin
                wd = $urandom;
                wr("rnd_w1c", 32'h10, wd, 0);
                if (wd[2]) m_ovr = 1'b0;
                rd("rnd_st_w1c", 32'h10, 32'({m_ovr, m_rxv, 1'b0}));
            end
        end

        // Reset during SHIFT aborts the frame
        loopback = 1'b1;
        wr("rst_div", 32'h04, 32'h3, 0);
        wr("rst_tx", 32'h08, 32'hFF, 0);
        for (int i = 0; i < BUDGET && !sclk; i++) @(negedge clk);
        check("rst_in_shift", 32'(sclk), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_csn", 32'(cs_n), 32'd1);
        check("abort_sclk", 32'(sclk), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        rd("abort_status", 32'h10, 32'h0);
        rd("abort_ctrl", 32'h00, 32'h0);
        rd("abort_div", 32'h04, 32'h0);
        rd("abort_rx", 32'h0C, 32'h0);
        check("abort_irq", 32'(irq), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: bench did not finish, %0d compared", n_cmp);
        $fatal(1);
    end

endmodule

// File: doc/spi_ctrl.md
Name: spi_ctrl

Overview:
- Back-end for the APB slave's register-access interface (rd_en/wr_en, addresses, data, ack/error strobes).
- Holds a five-register map and sequences a mode-0 SPI master transfer per TXDATA write.
- Applies back-pressure by withholding wack while a transfer is in flight.
- Sits between the APB slave and the SPI pads.

Parameters:
DATA_W, 8, SPI frame width in bits (1..32)
DIV_W, 8, width of clock-divider register

Ports:
clk  in  1  system clock
rst  in  1  reset: one clock; reset is synchronous and active-high
wr_en  in  1  write request, held until wack/waddrerr seen
rd_en  in  1  read request, held until rack/raddrerr seen
waddr  in  32  write byte address
raddr  in  32  read byte address
wdata  in  32  write data
rdata  out  32  read data, valid in the rack cycle
wack  out  1  write done, 1-cycle pulse
rack  out  1  read done, 1-cycle pulse
waddrerr  out  1  write error, 1-cycle pulse, replaces wack
raddrerr  out  1  read error, 1-cycle pulse, replaces rack
sclk  out  1  SPI clock, idle low
mosi  out  1  SPI data out, MSB first
miso  in  1  SPI data in
cs_n  out  1  chip select, active low
irq  out  1  CTRL.ie & STATUS.rx_valid

Behaviour:
- Reset: wack=rack=waddrerr=raddrerr=0, rdata=0, sclk=0, mosi=0, cs_n=1, CTRL=0, DIV=0, RXDATA=0, STATUS=0, engine IDLE. Reset mid-transfer aborts it; cs_n=1 on the next edge.
- Decode: addr[31:5]==0, addr[1:0]==0, index addr[4:2] in 0..4; anything else is an error.
- Map:
  - 0x00 CTRL RW [0]=en, [1]=ie.
  - 0x04 DIV RW [DIV_W-1:0].
  - 0x08 TXDATA WO; reads as 0.
  - 0x0C RXDATA RO.
  - 0x10 STATUS: [0]=busy RO, [1]=rx_valid RO, [2]=overrun W1C.
- Handshake:
  - Request is accepted only when wr_en (or rd_en) is high AND no strobe was issued in the previous cycle. This one-shot rule prevents a double accept, because the requester drops wr_en one cycle after the strobe.
  - Strobes are registered, so earliest response = 1 cycle after the request is first seen.
  - rdata is registered together with rack; otherwise rdata holds its last value.
  - wr_en and rd_en both high: write is served first, read on a later cycle.
- Write errors:
  - Write to RXDATA → waddrerr.
  - Write to TXDATA with CTRL.en=0 → waddrerr.
  - Decode fail → waddrerr.
  - Write to STATUS bits [1:0] ignored; no error.
- Read errors: decode fail → raddrerr.
- Write TXDATA while busy: wack is withheld; wr_en stays high. Once the engine returns to IDLE, the write is accepted, wack issues next cycle, and the new transfer starts.
- Write TXDATA while idle: latch wdata[DATA_W-1:0], busy=1, engine starts on the cycle after wack.
- Read RXDATA clears rx_valid in the rack cycle. If the engine completes in that same cycle, the set wins.
- Completion:
  - RXDATA <= shifted word, rx_valid <= 1.
  - If rx_valid was already 1, overrun <= 1 (sticky).
- Engine FSM, half-period H = DIV+1 clk cycles:
  - IDLE: cs_n=1, sclk=0. Start → LEAD.
  - LEAD: cs_n=0, mosi=MSB; hold H → SHIFT.
  - SHIFT: DATA_W sclk periods.
    - sclk rises after H; miso is sampled on the rising edge.
    - sclk falls after the next H; mosi shifts on the falling edge.
    - After the last falling edge → TRAIL.
  - TRAIL: hold H with sclk=0, cs_n=0; then cs_n=1, complete → IDLE.
  - Total transfer = (2·DATA_W+2)·H cycles from start to cs_n rising.
- DIV is sampled at start; writes to DIV during a transfer take effect on the next transfer. DIV=0 gives sclk = clk/2.
- Clearing CTRL.en mid-transfer does not abort the transfer.

Decomposition:
- Package spi_ctrl_pkg:
  - register offset localparams: CTRL, DIV, TXDATA, RXDATA, STATUS.
  - CTRL/STATUS bit-index constants.
  - engine state enum: IDLE, LEAD, SHIFT, TRAIL.
- Sub-module spi_shift_engine:
  - Inputs: start, div, txword.
  - Outputs: busy, done pulse, rxword, sclk/mosi/cs_n.
- Top holds the register bank and request/strobe logic.

Test Plan:
- Reset, then read 0x10 → rack, rdata=0; cs_n=1, sclk=0.
- Write CTRL=0x1, DIV=0x1, TXDATA=0xA5, with miso looped to mosi:
  - cs_n low for 36 cycles; mosi sequence 1,0,1,0,0,1,0,1.
  - Then STATUS=0x2, irq=0 (ie=0).
  - Read RXDATA=0xA5; next STATUS read=0x0.
- Write TXDATA=0x3C then immediately TXDATA=0xC3 → second wack arrives only after the first cs_n rises; two back-to-back frames.
- Two transfers without reading RXDATA → STATUS=0x6; write STATUS=0x4 → STATUS=0x2.
- Error cases, each a single error pulse with no ack:
  - Write 0x0C → waddrerr.
  - Read 0x14 → raddrerr.
  - Read 0x02 → raddrerr.
  - Write TXDATA with CTRL=0 → waddrerr.
- Assert rst during SHIFT → next cycle cs_n=1, sclk=0, STATUS=0, CTRL=0.
